// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result checker: opcodes, FSM encoding and
// the reference function also used by ALU bench models.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Widest operand the reference function handles; callers truncate.
  localparam int ALU_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } chk_state_t;

  // Low DATA_W bits of the result are exact mod 2^DATA_W for add/sub.
  function automatic logic [ALU_MAX_W-1:0] alu_ref(input logic [ALU_MAX_W-1:0] a,
                                                   input logic [ALU_MAX_W-1:0] b,
                                                   input logic [1:0]           op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return a | b;
    endcase
  endfunction

endpackage

// File: rtl/alu_delay_line.sv
// Fixed-depth shift register with a valid bit per stage; every stage advances
// each cycle. any_valid reports whether anything is still in flight.
module alu_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    vld_d[0]  = in_valid;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/alu_result_checker.sv
// Computes the expected ALU result at issue, delays it to line up with the
// ALU output, compares, and keeps session pass/fail statistics.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               check_en,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  A,
  input  logic [DATA_W-1:0]  B,
  input  logic [1:0]         opcode,
  input  logic [DATA_W-1:0]  result,
  output logic [COUNT_W-1:0] pass_count,
  output logic [COUNT_W-1:0] fail_count,
  output logic               mismatch,
  output logic               error,
  output logic [DATA_W-1:0]  fail_expected,
  output logic [DATA_W-1:0]  fail_actual,
  output logic [1:0]         fail_opcode,
  output logic               busy,
  output logic               done
);

  localparam int LW = DATA_W + 2;

  chk_state_t         state_q, state_d;
  logic [COUNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic               mismatch_q, mismatch_d;
  logic               error_q, error_d;
  logic [DATA_W-1:0]  fexp_q, fexp_d, fact_q, fact_d;
  logic [1:0]         fop_q, fop_d;

  logic               session_start;
  logic               s0_valid;
  logic [DATA_W-1:0]  s0_exp;
  logic               head_valid;
  logic [LW-1:0]      head_data;
  logic [DATA_W-1:0]  head_exp;
  logic [1:0]         head_op;
  logic               any_valid;

  assign s0_exp = DATA_W'(alu_ref(ALU_MAX_W'(A), ALU_MAX_W'(B), opcode));
  // Gating with check_en drops an op issued on the cycle the session ends.
  assign s0_valid = in_valid && check_en && (state_q == ST_RUN);

  alu_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (LW)
  ) u_dly (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s0_valid),
    .in_data   ({s0_exp, opcode}),
    .out_valid (head_valid),
    .out_data  (head_data),
    .any_valid (any_valid)
  );

  assign head_exp = head_data[LW-1:2];
  assign head_op  = head_data[1:0];

  always_comb begin
    state_d       = state_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    mismatch_d    = 1'b0;
    error_d       = error_q;
    fexp_d        = fexp_q;
    fact_d        = fact_q;
    fop_d         = fop_q;
    session_start = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: if (check_en) begin
        state_d       = ST_RUN;
        session_start = 1'b1;
      end
      ST_RUN:   if (!check_en) state_d = ST_DRAIN;
      ST_DRAIN: if (!any_valid) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    // The line is always empty when a session starts, so no compare is lost.
    if (session_start) begin
      pass_d  = '0;
      fail_d  = '0;
      error_d = 1'b0;
      fexp_d  = '0;
      fact_d  = '0;
      fop_d   = '0;
    end else if (head_valid) begin
      if (result == head_exp) begin
        if (pass_q != '1) pass_d = pass_q + COUNT_W'(1);
      end else begin
        if (fail_q != '1) fail_d = fail_q + COUNT_W'(1);
        mismatch_d = 1'b1;
        if (!error_q) begin
          error_d = 1'b1;
          fexp_d  = head_exp;
          fact_d  = result;
          fop_d   = head_op;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pass_q     <= '0;
      fail_q     <= '0;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
      fexp_q     <= '0;
      fact_q     <= '0;
      fop_q      <= '0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
      error_q    <= error_d;
      fexp_q     <= fexp_d;
      fact_q     <= fact_d;
      fop_q      <= fop_d;
    end
  end

  assign pass_count    = pass_q;
  assign fail_count    = fail_q;
  assign mismatch      = mismatch_q;
  assign error         = error_q;
  assign fail_expected = fexp_q;
  assign fail_actual   = fact_q;
  assign fail_opcode   = fop_q;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench: a two-stage ALU model with a per-op result override drives
// the checker; a second checker instance with 3-bit counters covers saturation.
module tb_alu_result_checker;

  logic       clk = 1'b0;
  logic       reset, check_en, in_valid;
  logic [7:0] A, B, result;
  logic [1:0] opcode;
  logic       ovr;
  logic [7:0] ovr_val;
  logic [7:0] r1, r2;

  logic [15:0] pass_count, fail_count;
  logic        mismatch, error, busy, done;
  logic [7:0]  fail_expected, fail_actual;
  logic [1:0]  fail_opcode;

  logic [2:0]  s_pass, s_fail;
  logic        s_mismatch, s_error, s_busy, s_done;
  logic [7:0]  s_fexp, s_fact;
  logic [1:0]  s_fop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU model: result sampled by the checker two edges after the operands.
  always_ff @(posedge clk) begin
    if (ovr) r1 <= ovr_val;
    else case (opcode)
      2'b00: r1 <= A + B;
      2'b01: r1 <= A - B;
      2'b10: r1 <= A & B;
      default: r1 <= A | B;
    endcase
    r2 <= r1;
  end
  assign result = r2;

  alu_result_checker #(.DATA_W(8), .LATENCY(2), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .check_en(check_en), .in_valid(in_valid),
    .A(A), .B(B), .opcode(opcode), .result(result),
    .pass_count(pass_count), .fail_count(fail_count), .mismatch(mismatch),
    .error(error), .fail_expected(fail_expected), .fail_actual(fail_actual),
    .fail_opcode(fail_opcode), .busy(busy), .done(done));

  alu_result_checker #(.DATA_W(8), .LATENCY(2), .COUNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .check_en(check_en), .in_valid(in_valid),
    .A(A), .B(B), .opcode(opcode), .result(result),
    .pass_count(s_pass), .fail_count(s_fail), .mismatch(s_mismatch),
    .error(s_error), .fail_expected(s_fexp), .fail_actual(s_fact),
    .fail_opcode(s_fop), .busy(s_busy), .done(s_done));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic o, input logic [7:0] ov);
    A = a; B = b; opcode = op; in_valid = 1'b1; ovr = o; ovr_val = ov;
    @(negedge clk);
    in_valid = 1'b0; ovr = 1'b0;
  endtask

  task automatic start_session();
    check_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_session(input string tag);
    logic seen;
    seen = 1'b0;
    check_en = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; check_en = 1'b0; in_valid = 1'b0;
    A = '0; B = '0; opcode = '0; ovr = 1'b0; ovr_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_pass", pass_count, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_err",  error, 0);
    chk("rst_mism", mismatch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic ops, back to back.
    start_session();
    chk("run_busy", busy, 1);
    issue(8'd10, 8'd5, 2'b00, 1'b0, 8'd0);
    issue(8'd20, 8'd8, 2'b01, 1'b0, 8'd0);
    issue(8'd6,  8'd3, 2'b10, 1'b0, 8'd0);
    issue(8'd4,  8'd1, 2'b11, 1'b0, 8'd0);
    end_session("basic_done");
    chk("basic_pass", pass_count, 4);
    chk("basic_fail", fail_count, 0);
    chk("basic_err",  error, 0);
    chk("basic_busy", busy, 0);

    // Wrap: ALU output pinned to the hand-computed values 44 and 254.
    start_session();
    chk("wrap_clr", pass_count, 0);
    chk("wrap_done_clr", done, 0);
    issue(8'd200, 8'd100, 2'b00, 1'b1, 8'd44);
    issue(8'd3,   8'd5,   2'b01, 1'b1, 8'd254);
    end_session("wrap_done");
    chk("wrap_pass", pass_count, 2);
    chk("wrap_fail", fail_count, 0);

    // Fault injection.
    start_session();
    issue(8'd10, 8'd5, 2'b00, 1'b1, 8'd13);
    chk("flt_mism_k1", mismatch, 0);
    @(negedge clk);
    chk("flt_mism_k2", mismatch, 0);
    @(negedge clk);
    chk("flt_mism_k3", mismatch, 1);
    chk("flt_fail1", fail_count, 1);
    chk("flt_err",   error, 1);
    chk("flt_fexp",  fail_expected, 15);
    chk("flt_fact",  fail_actual, 13);
    chk("flt_fop",   fail_opcode, 0);
    @(negedge clk);
    chk("flt_mism_k4", mismatch, 0);
    issue(8'd6, 8'd3, 2'b10, 1'b1, 8'd99);
    issue(8'd4, 8'd1, 2'b11, 1'b0, 8'd0);
    end_session("flt_done");
    chk("flt_fail2", fail_count, 2);
    chk("flt_pass",  pass_count, 1);
    chk("flt_err2",  error, 1);
    chk("flt_fexp2", fail_expected, 15);
    chk("flt_fact2", fail_actual, 13);
    chk("flt_fop2",  fail_opcode, 0);

    // Drain: the op issued with check_en low is dropped, DRAIN ignores in_valid.
    start_session();
    chk("drn_clr_err", error, 0);
    issue(8'd1, 8'd1, 2'b00, 1'b0, 8'd0);
    check_en = 1'b0;
    issue(8'd2, 8'd2, 2'b00, 1'b1, 8'd77);
    chk("drn_busy", busy, 1);
    chk("drn_done0", done, 0);
    issue(8'd3, 8'd3, 2'b00, 1'b1, 8'd88);
    chk("drn_done1", done, 0);
    chk("drn_pass1", pass_count, 1);
    @(negedge clk);
    chk("drn_done2", done, 1);
    chk("drn_pass", pass_count, 1);
    chk("drn_fail", fail_count, 0);

    // Reset with two bad ops in flight.
    start_session();
    issue(8'd9, 8'd9, 2'b00, 1'b1, 8'd1);
    issue(8'd7, 8'd7, 2'b00, 1'b1, 8'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_pass", pass_count, 0);
    chk("mrst_fail", fail_count, 0);
    chk("mrst_mism", mismatch, 0);
    chk("mrst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_mism2", mismatch, 0);
    chk("mrst_fail2", fail_count, 0);
    chk("mrst_busy2", busy, 1);
    issue(8'd12, 8'd3, 2'b01, 1'b0, 8'd0);
    end_session("mrst_done");
    chk("mrst_pass2", pass_count, 1);
    chk("mrst_fail3", fail_count, 0);
    chk("mrst_err",   error, 0);

    // Saturation on the 3-bit instance.
    start_session();
    for (int i = 0; i < 10; i++) issue(8'(i), 8'(i + 1), 2'b00, 1'b0, 8'd0);
    end_session("sat_done");
    chk("sat_pass", s_pass, 7);
    chk("sat_wide", pass_count, 10);
    start_session();
    chk("sat_clr", s_pass, 0);
    end_session("sat_done2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Hardware checker on the output side of the pipelined ALU.
- Taps the same operand/opcode stream that drives the ALU and computes the expected result at issue. It carries that value through a latency-matched delay line, compares it with the ALU's `result` when it emerges, and keeps pass/fail statistics.
- Sits beside the ALU in self-test builds. Also usable in the bench as a synthesizable scoreboard.

Parameters:
- DATA_W, 8, operand and result width.
- LATENCY, 2, edges from ALU operand sampling to `result` being sampled by the checker; legal range 1..8.
- COUNT_W, 16, width of the pass and fail counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- check_en  in  1  level; high = run a check session.
- in_valid  in  1  operands on A/B/opcode are issued to the ALU this cycle.
- A  in  DATA_W  operand A, same net as the ALU input.
- B  in  DATA_W  operand B, same net as the ALU input.
- opcode  in  2  same net as the ALU input.
- result  in  DATA_W  ALU output.
- pass_count  out  COUNT_W  matched checks.
- fail_count  out  COUNT_W  mismatched checks.
- mismatch  out  1  one-cycle pulse per failed check.
- error  out  1  sticky; set on first failure.
- fail_expected  out  DATA_W  expected value of the first failure.
- fail_actual  out  DATA_W  `result` at the first failure.
- fail_opcode  out  2  opcode of the first failure.
- busy  out  1  session running or draining.
- done  out  1  session complete, delay line empty.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: all outputs 0, FSM in IDLE, every delay-line valid bit 0. Reset mid-session discards in-flight entries; no counting occurs in the reset cycle.
- Reference function, mod 2^DATA_W:
  - 00 = A+B, wraps.
  - 01 = A−B, wraps.
  - 10 = A&B.
  - 11 = A|B.
- Delay line:
  - LATENCY stages, each holding {valid, expected, opcode}; shifts every cycle.
  - An op sampled at edge k reaches the compare point and is checked against `result` sampled at edge k+LATENCY.
  - Stage-0 valid = in_valid only while the FSM is in RUN; otherwise 0.
- Compare, at edge k+LATENCY when the head entry is valid:
  - Equal: pass_count +1.
  - Unequal: fail_count +1 and mismatch=1 for exactly the following cycle.
  - On the first failure since session start: error←1 and capture fail_expected, fail_actual and fail_opcode. Later failures do not overwrite the capture.
  - Both counters saturate at all-ones and never wrap.
- FSM states:
  - IDLE: busy=0, done=0. check_en=1 → RUN.
  - RUN: busy=1. On entry (same edge) clear counters, error, capture registers and done. check_en=0 → DRAIN.
  - DRAIN: busy=1. New in_valid is ignored; in-flight entries are still compared. When all stage valids are 0 → DONE.
  - DONE: busy=0, done=1; counters and captures hold. check_en=1 → RUN (clears as above).
- Ops issued while in IDLE or DONE are never checked.
- Back-to-back in_valid every cycle is supported; throughput is 1 check per cycle.
- check_en=0 for one cycle inside RUN: DRAIN completes normally. If check_en returns high while in DRAIN, it is honoured only after DONE.
- DRAIN with an empty delay line: → DONE on the next edge.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR.
  - the FSM state encoding.
  - a function alu_ref(a,b,op) returning the expected value. The ALU bench models share this function.
- One sub-module, alu_delay_line: parameterised depth and width, with a per-stage valid bit, synchronous clear on reset, and an any_valid output used by DRAIN.

Test Plan:
- Basic ops: issue (10,5,00), (20,8,01), (6,3,10), (4,1,11) on consecutive cycles with a correct ALU, then drop check_en → pass_count=4, fail_count=0, error=0, done=1 after the last compare.
- Wrap: issue (200,100,00) and (3,5,01) → expected values 44 and 254; pass_count=2.
- Fault injection: force `result` to 13 for the op (10,5,00) → mismatch pulses exactly 1 cycle at edge k+LATENCY+1. Captures are fail_expected=15, fail_actual=13, fail_opcode=00; error stays 1. A second forced failure leaves the captures unchanged and makes fail_count=2.
- Drain: deassert check_en in the same cycle as the last in_valid → that op is not counted (DRAIN). Ops issued one cycle earlier are still counted. done rises only after the delay line empties.
- Reset mid-flight: assert reset with 2 ops in flight → counters 0, no mismatch pulse. Restart RUN: only new ops are counted.
- Saturation: set COUNT_W=3 and feed 10 good ops → pass_count=7 and holds. A new session clears it to 0.
